// File: rtl/svo_tmds_pkg.sv
// rtl/svo_tmds_pkg.sv - TMDS control tokens and receive alignment states
package svo_tmds_pkg;

   localparam logic [9:0] TOK_CTRL_00 = 10'h354;
   localparam logic [9:0] TOK_CTRL_01 = 10'h0AB;
   localparam logic [9:0] TOK_CTRL_10 = 10'h154;
   localparam logic [9:0] TOK_CTRL_11 = 10'h2AB;

   typedef enum logic [1:0] {
      ST_SEARCH    = 2'd0,
      ST_SLIP_WAIT = 2'd1,
      ST_LOCKED    = 2'd2
   } tmds_state_t;

endpackage

// File: rtl/svo_tmds_sym_dec.sv
// rtl/svo_tmds_sym_dec.sv - combinational TMDS symbol decode and token classification
module svo_tmds_sym_dec
   import svo_tmds_pkg::*;
(
   input  logic [9:0] din,
   output logic [7:0] dout,
   output logic       is_token,
   output logic [1:0] ctrl
);

   logic [7:0] q;

   // din[9] marks an inverted payload, din[8] selects XOR vs XNOR chaining.
   always_comb begin
      q       = din[9] ? ~din[7:0] : din[7:0];
      dout    = '0;
      dout[0] = q[0];
      for (int i = 1; i < 8; i++) begin
         dout[i] = din[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      end
   end

   always_comb begin
      is_token = 1'b1;
      ctrl     = 2'b00;
      case (din)
         TOK_CTRL_00: ctrl = 2'b00;
         TOK_CTRL_01: ctrl = 2'b01;
         TOK_CTRL_10: ctrl = 2'b10;
         TOK_CTRL_11: ctrl = 2'b11;
         default:     is_token = 1'b0;
      endcase
   end

endmodule

// File: rtl/svo_tmds_dec.sv
// rtl/svo_tmds_dec.sv - TMDS channel decoder with bitslip-driven word alignment
module svo_tmds_dec
   import svo_tmds_pkg::*;
#(
   parameter int unsigned LOCK_TOKENS   = 8,
   parameter int unsigned SEARCH_WINDOW = 4096,
   parameter int unsigned SLIP_WAIT     = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] din,
   output logic [7:0] dout,
   output logic       de,
   output logic [1:0] ctrl,
   output logic       locked,
   output logic       bitslip
);

   localparam int RUN_W  = $clog2(LOCK_TOKENS) + 1;
   localparam int WIN_W  = $clog2(SEARCH_WINDOW) + 1;
   localparam int WAIT_W = $clog2(SLIP_WAIT) + 1;

   tmds_state_t       state_q, state_d;
   logic [RUN_W-1:0]  run_q, run_d, run_inc;
   logic [WIN_W-1:0]  win_q, win_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [7:0]        dout_q, dout_d;
   logic              de_q, de_d;
   logic [1:0]        ctrl_q, ctrl_d;
   logic              bitslip_q, bitslip_d;

   logic [7:0] sym_dout;
   logic       sym_is_token;
   logic [1:0] sym_ctrl;
   logic       run_complete;
   logic       win_expired;

   svo_tmds_sym_dec u_sym_dec (
      .din      (din),
      .dout     (sym_dout),
      .is_token (sym_is_token),
      .ctrl     (sym_ctrl)
   );

   // Any token extends the run so sync edges inside blanking keep it going.
   assign run_inc      = (run_q == RUN_W'(LOCK_TOKENS)) ? run_q : run_q + RUN_W'(1);
   assign run_complete = (state_q != ST_SLIP_WAIT) && sym_is_token
                         && (run_inc == RUN_W'(LOCK_TOKENS));
   assign win_expired  = (win_q == WIN_W'(SEARCH_WINDOW - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_SEARCH;
         run_q     <= '0;
         win_q     <= '0;
         wait_q    <= '0;
         dout_q    <= '0;
         de_q      <= 1'b0;
         ctrl_q    <= 2'b00;
         bitslip_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_q     <= run_d;
         win_q     <= win_d;
         wait_q    <= wait_d;
         dout_q    <= dout_d;
         de_q      <= de_d;
         ctrl_q    <= ctrl_d;
         bitslip_q <= bitslip_d;
      end
   end

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      wait_d  = wait_q;
      run_d   = sym_is_token ? run_inc : '0;
      case (state_q)
         ST_SEARCH: begin
            if (run_complete) begin
               state_d = ST_LOCKED;
               win_d   = '0;
            end else if (win_expired) begin
               state_d = ST_SLIP_WAIT;
               win_d   = '0;
               wait_d  = '0;
               run_d   = '0;
            end else begin
               win_d = win_q + WIN_W'(1);
            end
         end
         ST_SLIP_WAIT: begin
            run_d = '0;
            if (wait_q == WAIT_W'(SLIP_WAIT - 1)) begin
               state_d = ST_SEARCH;
               win_d   = '0;
               wait_d  = '0;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         ST_LOCKED: begin
            if (run_complete) begin
               win_d = '0;
            end else if (win_expired) begin
               state_d = ST_SEARCH;
               win_d   = '0;
               run_d   = '0;
            end else begin
               win_d = win_q + WIN_W'(1);
            end
         end
         default: begin
            state_d = ST_SEARCH;
            win_d   = '0;
            run_d   = '0;
         end
      endcase
   end

   // Gating uses the next state so the locking token already reports its ctrl code.
   always_comb begin
      bitslip_d = (state_q == ST_SEARCH) && !run_complete && win_expired;
      de_d      = (state_d == ST_LOCKED) && !sym_is_token;
      ctrl_d    = ((state_d == ST_LOCKED) && sym_is_token) ? sym_ctrl : 2'b00;
      dout_d    = ((state_q != ST_SLIP_WAIT) && !sym_is_token) ? sym_dout : dout_q;
   end

   assign dout    = dout_q;
   assign de      = de_q;
   assign ctrl    = ctrl_q;
   assign locked  = (state_q == ST_LOCKED);
   assign bitslip = bitslip_q;

endmodule

// File: doc/svo_tmds_dec.md
# svo_tmds_dec

TMDS channel decoder and word aligner for the HDMI receive path, the receive-side counterpart of `svo_tmds`. It takes raw 10-bit words from a per-channel 1:10 deserializer (IDES10) running on `clk_pixel`, and drives the deserializer's bitslip until control-token runs prove word alignment. It then decodes each symbol into 8-bit pixel data, data-enable and the 2-bit control code. One instance sits on each of the three channels; channel 0's `ctrl` carries {vsync, hsync}.

## Interface
Parameters:
- `LOCK_TOKENS`, default 8: consecutive control tokens that qualify alignment.
- `SEARCH_WINDOW`, default 4096: cycles allowed to find a qualifying run before slipping (SEARCH) or dropping lock (LOCKED). Must exceed one line period.
- `SLIP_WAIT`, default 16: cycles ignored after a bitslip pulse while the deserializer settles.

Ports:
- `clk`  in  1: pixel clock; all logic is on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `din`  in  10: raw deserialized word; `din[0]` is the first bit received (same ordering as `svo_tmds` `dout`).
- `dout`  out  8: decoded pixel byte.
- `de`  out  1: data enable; active-video symbol decoded.
- `ctrl`  out  2: decoded control code; valid when `de`=0.
- `locked`  out  1: word alignment established.
- `bitslip`  out  1: single-cycle pulse to the deserializer.

## Operation
- Control tokens: ctrl 00 = 10'h354, 01 = 10'h0AB, 10 = 10'h154, 11 = 10'h2AB. Any other word is a data symbol.
- Data decode:
  - q = din[9] ? ~din[7:0] : din[7:0].
  - d[0] = q[0].
  - For i = 1..7: d[i] = din[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]).
- Token run counter `run`:
  - Increments on a token of any kind, so hsync/vsync changes inside blanking do not break a run.
  - Clears to 0 on a data symbol.
  - Saturates at `LOCK_TOKENS`.
  - "Run complete" means `run` reaches `LOCK_TOKENS` on this cycle.
- State machine, three states, reset state SEARCH:
  - SEARCH:
    - `win` increments every cycle.
    - On run complete, go to LOCKED and clear `win`.
    - Otherwise, when `win` = SEARCH_WINDOW-1, pulse `bitslip`, go to SLIP_WAIT and clear `win` and `run`.
    - If the run completes on the same cycle the window expires, lock wins and no slip is issued.
  - SLIP_WAIT:
    - `din` is ignored and `run` is held at 0.
    - After `SLIP_WAIT` cycles, go to SEARCH with `win`=0.
  - LOCKED:
    - `win` clears on every run complete (including while saturated) and increments otherwise.
    - When `win` = SEARCH_WINDOW-1, go to SEARCH with `win` and `run` cleared. No bitslip is issued on loss of lock.
- Output gating:
  - When `locked`=0, `de` and `ctrl` are forced to 0.
  - `dout` always shows the decode of the last data symbol; it holds its value during tokens.
- Counter widths are `$clog2` of their limits plus 1. Counters never wrap.

## Timing
- Reset values: `dout`=0, `de`=0, `ctrl`=0, `locked`=0, `bitslip`=0; state SEARCH; `run`, `win` and the wait counter all 0.
- Reset applied mid-operation (any state) reaches these values on the first edge where reset is sampled high.
- Latency: all outputs are registered. A `din` sampled at edge k produces `dout`/`de`/`ctrl` valid after edge k.
- `locked` rises after the edge that samples the LOCK_TOKENS-th consecutive token. That token is itself decoded with `de`=0 and valid `ctrl`.
- `bitslip` is high for exactly one cycle.
- While alignment fails continuously, consecutive `bitslip` pulses are exactly SEARCH_WINDOW+SLIP_WAIT cycles apart. The first pulse comes SEARCH_WINDOW cycles after reset release.
- `locked` falls after the edge where `win` reaches SEARCH_WINDOW-1.

## Structure
- Shared package `svo_tmds_pkg` holds:
  - the four control-token constants;
  - the state enum (SEARCH, SLIP_WAIT, LOCKED).
- `svo_tmds` uses the same token constants from this package.
- One sub-module, `svo_tmds_sym_dec`: the combinational 10b→8b decode plus token classification (is_token, ctrl value).
- The alignment FSM and counters live in the top.

## Test plan
1. Reset held 3 cycles during a random `din` stream → all outputs 0 and no `bitslip` while reset is high and on the first cycle after.
2. Aligned stream: repeating 700 × 10'h100 then 100 × 10'h354. Expected:
   - `locked` rises after the 8th token;
   - active symbols give `dout`=8'h00, `de`=1;
   - blanking gives `de`=0, `ctrl`=00;
   - no `bitslip` ever.
3. Decode coverage after lock:
   - 10'h200 → `dout`=8'hFF;
   - 10'h0AB, 10'h154, 10'h2AB → `ctrl` 01, 10, 11, with `dout` holding its previous value;
   - a run alternating 10'h354/10'h0AB still locks.
4. Misalignment: the bench rotates the stream by 3 bits and un-rotates it one bit per `bitslip` pulse. Expected:
   - exactly 3 pulses, at cycles 4096, 8208 and 12320 after reset release;
   - then `locked`=1 within one line.
5. Loss of lock: once locked, feed only 10'h100 → `locked` and `de` fall after 4096 cycles, with no `bitslip` on the drop. Re-lock requires a fresh 8-token run.
6. Reset asserted during SLIP_WAIT and during LOCKED → state SEARCH and `locked`=0 on the next cycle. The next slip comes a full 4096 cycles after release.
